transmit_ordered_set: RTL
=========================

Name: transmit_ordered_set

Overview:
PCS transmit ordered-set state machine (1000BASE-X Clause 36 style, full duplex, no carrier extension). It sits directly upstream of the code-group transmitter. It converts GMII TX_EN/TX_ER framing into the ordered-set selector TX_O_SET (/I/, /S/, /D/, /V/, /T/, /R/). It paces itself on TX_OSET_indicate and tx_even returned by the code-group transmitter. TXD bypasses this block and goes straight to the code-group transmitter.

Parameters:
CNT_W, 16, width of frame and error counters.

Ports:
GTX_CLK  in  1  transmit clock; all logic on the rising edge.
mr_main_reset  in  1  reset, synchronous, active-high.
TX_EN  in  1  GMII transmit enable.
TX_ER  in  1  GMII transmit error.
TX_OSET_indicate  in  1  from the code-group transmitter; current ordered set is complete.
tx_even  in  1  from the code-group transmitter; parity of the code group just sent.
TX_O_SET  out  7  ordered-set selector: OS_T=1, OS_R=2, OS_I=3, OS_D=4, OS_S=5, OS_V=6; 0 and 7 are never driven.
transmitting  out  1  high while a frame is in progress.
tx_state  out  4  state encoding, for debug.
frame_cnt  out  CNT_W  number of frames completed via /T/.
err_cnt  out  CNT_W  number of frames containing at least one /V/.

Behaviour:
- Moore machine. TX_O_SET and transmitting are registered and decoded from state.
- The state advances only on an edge where TX_OSET_indicate=1. Otherwise it holds.
- Latency: TX_O_SET reflects a new state one cycle after the indicate edge.
- Reset (sampled high on an edge): state=XMIT_DATA, TX_O_SET=OS_I, transmitting=0, frame_cnt=0, err_cnt=0. Reset overrides everything, including a mid-frame reset, which drops straight to /I/ with no /T/ or /R/.
- States, with the output of each and the transition taken on indicate:
  - XMIT_DATA (0), TX_O_SET=OS_I, transmitting=0:
    - TX_EN=1, TX_ER=0 -> START_OF_PACKET.
    - TX_EN=1, TX_ER=1 -> START_ERROR.
    - Otherwise stay.
  - START_OF_PACKET (1), OS_S, transmitting=1: goes to the packet decision.
  - START_ERROR (2), OS_S, transmitting=1: goes to TX_DATA_ERROR.
  - TX_DATA (3), OS_D, transmitting=1: goes to the packet decision.
  - TX_DATA_ERROR (4), OS_V, transmitting=1: goes to the packet decision.
  - END_OF_PACKET (5), OS_T, transmitting=0: goes to EPD2.
  - EPD2 (6), OS_R, transmitting=0:
    - tx_even=0 -> XMIT_DATA.
    - tx_even=1 -> EPD3.
  - EPD3 (7), OS_R, transmitting=0: goes to XMIT_DATA.
- Packet decision:
  - TX_EN=1, TX_ER=0 -> TX_DATA.
  - TX_EN=1, TX_ER=1 -> TX_DATA_ERROR.
  - TX_EN=0 -> END_OF_PACKET, regardless of TX_ER.
- Alignment: EPD2/EPD3 guarantee that /I/ starts on an even code group.
- TX_EN and TX_ER are sampled only on indicate edges. Changes between indicate edges are ignored.
- frame_cnt increments on the edge entering END_OF_PACKET.
- err_cnt increments once per frame, on entering END_OF_PACKET, if a per-frame error flag is set. The flag is set on entry to TX_DATA_ERROR and cleared in XMIT_DATA.
- Both counters wrap modulo 2^CNT_W. Reset clears the counters and the error flag.
- Undefined state encodings recover to XMIT_DATA on the next edge.

Test Plan:
Bench model: TX_OSET_indicate=1 every cycle, except 0 on the first cycle of each /I/; tx_even toggles per code group.
- Reset 3 cycles, then release with TX_EN=0 -> TX_O_SET=3 (OS_I) continuously; transmitting=0; counters=0.
- Clean frame: TX_EN=1 for 4 indicates -> TX_O_SET sequence 5,4,4,4,1,2 (+2 if tx_even=1 at EPD2), then 3. transmitting=1 from S through the last D. frame_cnt=1, err_cnt=0.
- Error mid-frame: TX_ER=1 on the 2nd data indicate -> sequence 5,4,6,4,1,2,... ; err_cnt=1; a second error in the same frame leaves err_cnt=1.
- Start error: TX_EN=1, TX_ER=1 at start -> 5,6, then D/T per TX_EN; err_cnt increments at /T/.
- Hold: TX_OSET_indicate=0 for 5 cycles while in TX_DATA, with TX_EN toggling -> TX_O_SET stays 4 and state unchanged.
- Reset mid-frame, then preload frame_cnt=2^CNT_W-1 and end a frame: reset gives OS_I on the next cycle with counters 0; the wrap case gives frame_cnt=0.

Source files
------------

// File: rtl/transmit_ordered_set.sv
// PCS transmit ordered-set state machine: turns GMII TX_EN/TX_ER framing into
// the /I/ /S/ /D/ /V/ /T/ /R/ selector, paced by the code-group transmitter.
module transmit_ordered_set #(
  parameter int CNT_W = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic             TX_OSET_indicate,
  input  logic             tx_even,
  output logic [6:0]       TX_O_SET,
  output logic             transmitting,
  output logic [3:0]       tx_state,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [6:0] OS_T = 7'd1;
  localparam logic [6:0] OS_R = 7'd2;
  localparam logic [6:0] OS_I = 7'd3;
  localparam logic [6:0] OS_D = 7'd4;
  localparam logic [6:0] OS_S = 7'd5;
  localparam logic [6:0] OS_V = 7'd6;

  typedef enum logic [3:0] {
    XMIT_DATA       = 4'd0,
    START_OF_PACKET = 4'd1,
    START_ERROR     = 4'd2,
    TX_DATA         = 4'd3,
    TX_DATA_ERROR   = 4'd4,
    END_OF_PACKET   = 4'd5,
    EPD2            = 4'd6,
    EPD3            = 4'd7
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   err_flag;

  // Shared decision taken after /S/, /D/ and /V/; TX_ER is ignored once TX_EN drops.
  function automatic state_t packet_decision(input logic en, input logic er);
    if (!en)
      return END_OF_PACKET;
    else if (er)
      return TX_DATA_ERROR;
    else
      return TX_DATA;
  endfunction

  function automatic logic [6:0] oset_of(input state_t s);
    case (s)
      START_OF_PACKET, START_ERROR: return OS_S;
      TX_DATA:                      return OS_D;
      TX_DATA_ERROR:                return OS_V;
      END_OF_PACKET:                return OS_T;
      EPD2, EPD3:                   return OS_R;
      default:                      return OS_I;
    endcase
  endfunction

  function automatic logic transmitting_of(input state_t s);
    case (s)
      START_OF_PACKET, START_ERROR, TX_DATA, TX_DATA_ERROR: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Illegal encodings fall through to default and recover without waiting for indicate.
  always_comb begin
    state_nxt = state;
    case (state)
      XMIT_DATA:
        if (TX_OSET_indicate && TX_EN)
          state_nxt = TX_ER ? START_ERROR : START_OF_PACKET;
      START_OF_PACKET, TX_DATA, TX_DATA_ERROR:
        if (TX_OSET_indicate)
          state_nxt = packet_decision(TX_EN, TX_ER);
      START_ERROR:
        if (TX_OSET_indicate)
          state_nxt = TX_DATA_ERROR;
      END_OF_PACKET:
        if (TX_OSET_indicate)
          state_nxt = EPD2;
      EPD2:
        if (TX_OSET_indicate)
          state_nxt = tx_even ? EPD3 : XMIT_DATA;
      EPD3:
        if (TX_OSET_indicate)
          state_nxt = XMIT_DATA;
      default:
        state_nxt = XMIT_DATA;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as state.
  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state        <= XMIT_DATA;
      TX_O_SET     <= OS_I;
      transmitting <= 1'b0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
      err_flag     <= 1'b0;
    end else begin
      state        <= state_nxt;
      TX_O_SET     <= oset_of(state_nxt);
      transmitting <= transmitting_of(state_nxt);

      if (state_nxt == TX_DATA_ERROR)
        err_flag <= 1'b1;
      else if (state == XMIT_DATA)
        err_flag <= 1'b0;

      if (state_nxt == END_OF_PACKET && state != END_OF_PACKET) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (err_flag)
          err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign tx_state = state;

endmodule
